sha256_host: RTL and testbench

SHA256_HOST -- requirements
Module: sha256_host

---
 rtl/sha256_pkg.sv | 11 +
 rtl/sha256_msg_buf.sv | 20 ++
 rtl/sha256_host.sv | 125 ++++++++++++
 tb/tb_sha256_host.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and sizing for the SHA-256 host sequencer.
package sha256_pkg;
  localparam int WORDS_IN  = 16;
  localparam int WORDS_OUT = 8;
  localparam int WORD_W    = 32;
  localparam int IDX_W     = 4;

  typedef enum logic [2:0] {
    IDLE, FILL, LOAD, WAIT, READ, DONE, ERR
  } state_t;
endpackage

// File: rtl/sha256_msg_buf.sv
// 16x32 message store: one synchronous write port, one asynchronous read port.
module sha256_msg_buf
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [WORDS_IN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Combinational read so word 0 is on the bus in the first LOAD cycle.
  assign rdata = mem[raddr];
endmodule

// File: rtl/sha256_host.sv
// Host-side sequencer: buffers a 512-bit block, loads it into the hash core,
// waits for end-of-conversion and reads back the 256-bit digest.
//   state | meaning
//   IDLE  | waiting for start
//   FILL  | accepting 16 message words
//   LOAD  | streaming 16 words to the core with sha_soc/sha_doe
//   WAIT  | sha_soc held, waiting for sha_eoc or timeout
//   READ  | reading 8 digest words with sha_rd
//   DONE  | one-cycle digest_valid
//   ERR   | one-cycle err after timeout
module sha256_host
  import sha256_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              msg_valid,
  input  logic [WORD_W-1:0] msg_data,
  output logic              msg_ready,
  output logic [255:0]      digest,
  output logic              digest_valid,
  output logic              busy,
  output logic              err,
  output logic              sha_soc,
  output logic              sha_rd,
  input  logic              sha_eoc,
  output logic [WORD_W-1:0] sha_dout,
  output logic              sha_doe,
  input  logic [WORD_W-1:0] sha_din
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(WORDS_IN - 1);
  localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(WORDS_OUT - 1);

  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt;
  logic [CW-1:0] wait_cnt;
  logic [WORDS_OUT-1:0][WORD_W-1:0] dig_q;
  logic [WORD_W-1:0] buf_rdata;
  logic buf_we;

  assign buf_we = (state_q == FILL) && msg_valid;
  assign digest = dig_q;

  sha256_msg_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt),
    .wdata (msg_data),
    .raddr (cnt),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt      <= '0;
      wait_cnt <= '0;
      dig_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (state_q == WAIT && state_d == WAIT) ? wait_cnt + CW'(1) : '0;
      case (state_q)
        FILL: if (msg_valid) cnt <= (cnt == LAST_IN) ? '0 : cnt + IDX_ONE;
        LOAD: cnt <= (cnt == LAST_IN) ? '0 : cnt + IDX_ONE;
        READ: begin
          // digest word 0 lives in the top bits
          dig_q[3'(WORDS_OUT - 1) - cnt[2:0]] <= sha_din;
          cnt <= (cnt == LAST_OUT) ? '0 : cnt + IDX_ONE;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    msg_ready    = 1'b0;
    busy         = 1'b1;
    sha_soc      = 1'b0;
    sha_rd       = 1'b0;
    sha_doe      = 1'b0;
    sha_dout     = '0;
    digest_valid = 1'b0;
    err          = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FILL;
      end
      FILL: begin
        msg_ready = 1'b1;
        if (msg_valid && cnt == LAST_IN) state_d = LOAD;
      end
      LOAD: begin
        sha_soc  = 1'b1;
        sha_doe  = 1'b1;
        sha_dout = buf_rdata;
        if (cnt == LAST_IN) state_d = WAIT;
      end
      WAIT: begin
        sha_soc = 1'b1;
        if (sha_eoc) state_d = READ;
        else if (wait_cnt == CW'(TIMEOUT)) state_d = ERR;
      end
      READ: begin
        sha_soc = 1'b1;
        sha_rd  = 1'b1;
        if (cnt == LAST_OUT) state_d = DONE;
      end
      DONE: begin
        digest_valid = 1'b1;
        state_d      = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sha256_host.sv
// Bench for sha256_host with a behavioural SHA-256 core model on the core bus.
module tb_sha256_host;
  localparam logic [255:0] ABC_D =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic clk = 1'b0;
  logic rst_n, start, msg_valid, msg_ready, digest_valid, busy, err;
  logic sha_soc, sha_rd, sha_eoc, sha_doe;
  logic [31:0] msg_data, sha_dout, sha_din;
  logic [255:0] digest;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sha256_host #(.TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_valid(msg_valid),
    .msg_data(msg_data), .msg_ready(msg_ready), .digest(digest),
    .digest_valid(digest_valid), .busy(busy), .err(err), .sha_soc(sha_soc),
    .sha_rd(sha_rd), .sha_eoc(sha_eoc), .sha_dout(sha_dout), .sha_doe(sha_doe),
    .sha_din(sha_din)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3];
    e = H0[4]; f = H0[5]; g = H0[6]; h = H0[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + H0[0], b + H0[1], c + H0[2], d + H0[3],
            e + H0[4], f + H0[5], g + H0[6], h + H0[7]};
  endfunction

  // Hash core model: collects the loaded block, raises eoc after eoc_lat cycles,
  // then serves digest words in order on each sha_rd.
  bit core_en = 1'b1;
  int eoc_lat = 2;
  logic [511:0] core_blk;
  logic [255:0] core_hash = '0;
  int core_wi, core_ri, core_dly;
  logic core_eoc;

  assign sha_eoc = core_eoc;
  assign sha_din = core_hash[255-32*core_ri -: 32];

  always @(posedge clk) begin
    if (!rst_n) begin
      core_wi <= 0; core_ri <= 0; core_dly <= -1; core_eoc <= 1'b0;
    end else begin
      if (sha_doe) begin
        core_blk <= {core_blk[479:0], sha_dout};
        core_wi <= (core_wi == 15) ? 0 : core_wi + 1;
        if (core_wi == 15 && core_en) core_dly <= eoc_lat;
      end else if (core_dly > 0) begin
        core_dly <= core_dly - 1;
      end else if (core_dly == 0) begin
        core_hash <= sha256_blk(core_blk);
        core_eoc <= 1'b1;
        core_dly <= -1;
      end
      if (sha_rd) begin
        core_eoc <= 1'b0;
        core_ri <= (core_ri == 7) ? 0 : core_ri + 1;
      end
    end
  end

  // Bus monitor
  logic [31:0] doe_words [$];
  int runs [$];
  int doe_run = 0, wait_cur = 0, last_wait = 0;
  int dv_total = 0, err_total = 0, overlap = 0;

  always @(negedge clk) begin
    if (sha_doe) begin
      doe_words.push_back(sha_dout);
      doe_run++;
    end else if (doe_run != 0) begin
      runs.push_back(doe_run);
      doe_run = 0;
    end
    if (sha_soc && !sha_doe && !sha_rd) wait_cur++;
    else if (wait_cur != 0) begin
      last_wait = wait_cur;
      wait_cur = 0;
    end
    if (digest_valid) dv_total++;
    if (err) err_total++;
    if (sha_doe && sha_rd) overlap++;
  end

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[511-32*k -: 32] = $urandom();
    return b;
  endfunction

  task automatic send_block(input logic [511:0] blk, input bit gaps);
    int k = 0;
    int guard = 0;
    bit hs;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < 16 && guard < 200) begin
      msg_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      msg_data = blk[511-32*k -: 32];
      hs = msg_valid && msg_ready;
      @(negedge clk);
      if (hs) k++;
      guard++;
    end
    msg_valid = 1'b0;
    msg_data = '0;
    if (k != 16) begin
      n_total++;
      $display("FAIL fill_handshake: accepted %0d words, required 16", k);
    end
  endtask

  task automatic wait_end(output bit got_dv, output bit got_err, output bit timed_out);
    got_dv = 0; got_err = 0; timed_out = 1;
    for (int i = 0; i < 300; i++) begin
      if (digest_valid || err) begin
        got_dv = digest_valid; got_err = err; timed_out = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; msg_valid = 1'b0; msg_data = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, msg_ready, sha_soc, sha_rd, sha_doe, err, digest_valid} !== 7'b0)
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, msg_ready, sha_soc, sha_rd, sha_doe, err, digest_valid});
    else n_pass++;
    n_total++;
    if (sha_dout !== 32'h0) $display("FAIL reset_dout: got %h required 0", sha_dout);
    else n_pass++;
    n_total++;
    if (digest !== 256'h0) $display("FAIL reset_digest: got %h required 0", digest);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_known(input string name, input logic [511:0] blk, input logic [255:0] exp);
    int dv0, w0, bad;
    bit dv, er, to;
    dv0 = dv_total; w0 = doe_words.size(); bad = 0;
    eoc_lat = $urandom_range(0, 6);
    send_block(blk, 1'b0);
    wait_end(dv, er, to);
    n_total++;
    if (to || !dv) $display("FAIL %s_done: got dv=%0b err=%0b timeout=%0b required dv=1", name, dv, er, to);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (digest !== exp) $display("FAIL %s_digest: got %h required %h", name, digest, exp);
    else n_pass++;
    n_total++;
    if (dv_total - dv0 !== 1) $display("FAIL %s_dv_count: got %0d required 1", name, dv_total - dv0);
    else n_pass++;
    for (int k = 0; k < 16; k++)
      if (doe_words.size() < w0 + 16 || doe_words[w0+k] !== blk[511-32*k -: 32]) bad++;
    n_total++;
    if (bad != 0) $display("FAIL %s_load_words: got %0d wrong words required 0", name, bad);
    else n_pass++;
  endtask

  task automatic test_abc();
    run_known("abc", {32'h61626380, {14{32'h0}}, 32'h00000018}, ABC_D);
  endtask

  task automatic test_empty();
    run_known("empty", {32'h80000000, {15{32'h0}}}, EMPTY_D);
  endtask

  task automatic test_fill_gaps();
    logic [511:0] blk;
    int r0, w0, bad;
    bit dv, er, to;
    for (int t = 0; t < 3; t++) begin
      blk = rand_blk();
      r0 = runs.size(); w0 = doe_words.size(); bad = 0;
      eoc_lat = $urandom_range(0, 8);
      send_block(blk, 1'b1);
      wait_end(dv, er, to);
      repeat (2) @(negedge clk);
      n_total++;
      if (runs.size() != r0 + 1 || runs[r0] != 16)
        $display("FAIL gaps_doe_run: got %0d runs last %0d required 1 run of 16",
                 runs.size() - r0, (runs.size() > r0) ? runs[r0] : 0);
      else n_pass++;
      for (int k = 0; k < 16; k++)
        if (doe_words.size() < w0 + 16 || doe_words[w0+k] !== blk[511-32*k -: 32]) bad++;
      n_total++;
      if (bad != 0) $display("FAIL gaps_word_order: got %0d wrong words required 0", bad);
      else n_pass++;
      n_total++;
      if (!dv || digest !== sha256_blk(blk))
        $display("FAIL gaps_digest: got %h required %h", digest, sha256_blk(blk));
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [255:0] saved;
    int dv0;
    bit dv, er, to;
    saved = digest; dv0 = dv_total;
    core_en = 1'b0;
    send_block(rand_blk(), 1'b0);
    wait_end(dv, er, to);
    n_total++;
    if (to || !er || dv) $display("FAIL timeout_err: got err=%0b dv=%0b timeout=%0b required err=1", er, dv, to);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (last_wait != 21) $display("FAIL timeout_wait_cycles: got %0d required 21", last_wait);
    else n_pass++;
    n_total++;
    if (sha_soc !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL timeout_idle: got soc=%b busy=%b err=%b required 0 0 0", sha_soc, busy, err);
    else n_pass++;
    n_total++;
    if (digest !== saved || dv_total != dv0)
      $display("FAIL timeout_digest_held: got %h required %h", digest, saved);
    else n_pass++;
    core_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit found = 0;
    core_en = 1'b0;
    send_block(rand_blk(), 1'b0);
    for (int g = 0; g < 100 && !found; g++) begin
      if (sha_soc && !sha_doe && !sha_rd) begin
        if (n == 5) found = 1;
        else n++;
      end
      if (!found) @(negedge clk);
    end
    n_total++;
    if (!found) $display("FAIL rstmid_reach_wait: got %0d wait cycles required 5", n);
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_total++;
    if (sha_soc !== 1'b0 || busy !== 1'b0 || digest !== 256'h0)
      $display("FAIL rstmid_idle: got soc=%b busy=%b digest=%h required 0", sha_soc, busy, digest);
    else n_pass++;
    rst_n = 1'b1;
    core_en = 1'b1;
    @(negedge clk);
    test_abc();
  endtask

  task automatic test_start_busy();
    logic [511:0] blk;
    int dv0;
    bit found = 0;
    bit dv, er, to;
    blk = rand_blk(); dv0 = dv_total;
    eoc_lat = 3;
    send_block(blk, 1'b0);
    for (int g = 0; g < 100 && !found; g++) begin
      if (sha_rd) found = 1;
      else @(negedge clk);
    end
    n_total++;
    if (!found) $display("FAIL busy_reach_read: got no sha_rd required READ");
    else n_pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(dv, er, to);
    repeat (5) @(negedge clk);
    n_total++;
    if (dv_total - dv0 != 1) $display("FAIL busy_dv_count: got %0d required 1", dv_total - dv0);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || msg_ready !== 1'b0)
      $display("FAIL busy_start_ignored: got busy=%b ready=%b required 0 0", busy, msg_ready);
    else n_pass++;
    n_total++;
    if (digest !== sha256_blk(blk)) $display("FAIL busy_digest: got %h required %h", digest, sha256_blk(blk));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [511:0] blk;
    bit dv, er, to;
    for (int t = 0; t < 4; t++) begin
      blk = rand_blk();
      eoc_lat = $urandom_range(0, 10);
      send_block(blk, t[0]);
      wait_end(dv, er, to);
      n_total++;
      if (!dv || digest !== sha256_blk(blk))
        $display("FAIL b2b_digest: got %h required %h", digest, sha256_blk(blk));
      else n_pass++;
    end
    n_total++;
    if (overlap != 0) $display("FAIL doe_rd_overlap: got %0d cycles required 0", overlap);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_fill_gaps();
    test_timeout();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
